// File: rtl/hour_counter.sv
// rtl/hour_counter.sv - hour register with load, minute advance, button set FSM and 12/24h BCD decode
//
// Ports:
//   clk           system clock, all state on rising edge
//   reset         asynchronous active-low reset
//   minute_enable one-cycle advance pulse, honoured only when set_mode is low
//   load1         one-cycle load strobe, highest priority
//   load_value    hour to load; values above 23 are ignored
//   set_mode      manual set mode; enables btn_up/btn_down, drops minute_enable
//   btn_up        debounced increment level
//   btn_down      debounced decrement level
//   mode_12h      display format: 1 = 12-hour, 0 = 24-hour
//   hour          registered binary hour 0-23
//   disp_tens     BCD tens digit of displayed hour
//   disp_ones     BCD ones digit of displayed hour
//   pm            hour >= 12
//   thresh        hour == 23
//   day_tick      registered pulse after a minute-driven 23->0 wrap
module hour_counter #(
  parameter int REPEAT_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       minute_enable,
  input  logic       load1,
  input  logic [4:0] load_value,
  input  logic       set_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       mode_12h,
  output logic [4:0] hour,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       pm,
  output logic       thresh,
  output logic       day_tick
);

  localparam int CW = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD_UP,
    HELD_DOWN
  } btn_state_e;

  btn_state_e    state_q, state_d;
  logic [4:0]    hour_q, hour_d;
  logic          day_tick_q, day_tick_d;
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  // Set while a button that was held through a load or reset is still down;
  // the FSM ignores presses until both buttons have been released once.
  logic          blocked_q, blocked_d;

  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [4:0] hour_dec(input logic [4:0] h);
    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    hour_d     = hour_q;
    day_tick_d = 1'b0;
    rpt_cnt_d  = rpt_cnt_q;
    blocked_d  = blocked_q;

    if (!btn_up && !btn_down) begin
      blocked_d = 1'b0;
    end

    if (load1) begin
      if (load_value <= 5'd23) begin
        hour_d = load_value;
      end
      state_d   = IDLE;
      rpt_cnt_d = '0;
      if (btn_up || btn_down) begin
        blocked_d = 1'b1;
      end
    end else if (set_mode) begin
      case (state_q)
        IDLE: begin
          rpt_cnt_d = '0;
          if (!blocked_q) begin
            if (btn_up && !btn_down) begin
              state_d = HELD_UP;
              hour_d  = hour_inc(hour_q);
            end else if (btn_down && !btn_up) begin
              state_d = HELD_DOWN;
              hour_d  = hour_dec(hour_q);
            end
          end
        end
        HELD_UP: begin
          if (!btn_up || btn_down) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == RPT_LAST) begin
            hour_d    = hour_inc(hour_q);
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        HELD_DOWN: begin
          if (!btn_down || btn_up) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == RPT_LAST) begin
            hour_d    = hour_dec(hour_q);
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end else begin
      // Leaving set mode aborts any hold; minute advance only applies here.
      state_d   = IDLE;
      rpt_cnt_d = '0;
      if (minute_enable) begin
        hour_d     = hour_inc(hour_q);
        day_tick_d = (hour_q == 5'd23);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hour_q     <= 5'd0;
      day_tick_q <= 1'b0;
      rpt_cnt_q  <= '0;
      blocked_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hour_q     <= hour_d;
      day_tick_q <= day_tick_d;
      rpt_cnt_q  <= rpt_cnt_d;
      blocked_q  <= blocked_d;
    end
  end

  // Display decode straight from the hour register, no added latency.
  logic [4:0] disp_val;
  logic [4:0] ones_wide;

  always_comb begin
    disp_val = hour_q;
    if (mode_12h) begin
      if (hour_q == 5'd0) begin
        disp_val = 5'd12;
      end else if (hour_q > 5'd12) begin
        disp_val = hour_q - 5'd12;
      end
    end

    if (disp_val >= 5'd20) begin
      disp_tens = 4'd2;
      ones_wide = disp_val - 5'd20;
    end else if (disp_val >= 5'd10) begin
      disp_tens = 4'd1;
      ones_wide = disp_val - 5'd10;
    end else begin
      disp_tens = 4'd0;
      ones_wide = disp_val;
    end
    disp_ones = ones_wide[3:0];
  end

  assign hour     = hour_q;
  assign day_tick = day_tick_q;
  assign pm       = (hour_q >= 5'd12);
  assign thresh   = (hour_q == 5'd23);

endmodule

// File: tb/tb_hour_counter.sv
// tb/tb_hour_counter.sv - directed self-checking bench for hour_counter
module tb_hour_counter;

  logic       clk;
  logic       reset;
  logic       minute_enable;
  logic       load1;
  logic [4:0] load_value;
  logic       set_mode;
  logic       btn_up;
  logic       btn_down;
  logic       mode_12h;
  logic [4:0] hour;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic       pm;
  logic       thresh;
  logic       day_tick;

  int total;
  int bad;

  hour_counter #(.REPEAT_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .minute_enable(minute_enable),
    .load1        (load1),
    .load_value   (load_value),
    .set_mode     (set_mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .mode_12h     (mode_12h),
    .hour         (hour),
    .disp_tens    (disp_tens),
    .disp_ones    (disp_ones),
    .pm           (pm),
    .thresh       (thresh),
    .day_tick     (day_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] v);
    load_value = v;
    load1      = 1'b1;
    tick();
    load1      = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    total++; if (hour !== 5'd0) begin bad++; $display("FAIL reset_async_hour got=%0d exp=0", hour); end
    tick();
    tick();
    total++; if (day_tick !== 1'b0) begin bad++; $display("FAIL reset_day_tick got=%0b exp=0", day_tick); end
    total++; if (disp_tens !== 4'd0 || disp_ones !== 4'd0) begin bad++; $display("FAIL reset_disp24 got=%0d/%0d exp=0/0", disp_tens, disp_ones); end
    total++; if (pm !== 1'b0 || thresh !== 1'b0) begin bad++; $display("FAIL reset_pm_thresh got=%0b/%0b exp=0/0", pm, thresh); end
    mode_12h = 1'b1;
    #1;
    total++; if (disp_tens !== 4'd1 || disp_ones !== 4'd2) begin bad++; $display("FAIL reset_disp12 got=%0d/%0d exp=1/2", disp_tens, disp_ones); end
    mode_12h = 1'b0;
    reset    = 1'b1;
    tick();
    total++; if (hour !== 5'd0) begin bad++; $display("FAIL reset_release_hour got=%0d exp=0", hour); end
  endtask

  task automatic test_minute;
    do_load(5'd5);
    minute_enable = 1'b1;
    tick();
    minute_enable = 1'b0;
    total++; if (hour !== 5'd6 || day_tick !== 1'b0) begin bad++; $display("FAIL minute_inc got=%0d/%0b exp=6/0", hour, day_tick); end
    do_load(5'd23);
    total++; if (hour !== 5'd23 || thresh !== 1'b1 || day_tick !== 1'b0) begin bad++; $display("FAIL load23 got=%0d thr=%0b dt=%0b exp=23/1/0", hour, thresh, day_tick); end
    minute_enable = 1'b1;
    tick();
    minute_enable = 1'b0;
    total++; if (hour !== 5'd0 || day_tick !== 1'b1 || thresh !== 1'b0) begin bad++; $display("FAIL minute_wrap got=%0d dt=%0b thr=%0b exp=0/1/0", hour, day_tick, thresh); end
    tick();
    total++; if (hour !== 5'd0 || day_tick !== 1'b0) begin bad++; $display("FAIL day_tick_width got=%0d dt=%0b exp=0/0", hour, day_tick); end
  endtask

  task automatic test_load_display;
    do_load(5'd13);
    total++; if (hour !== 5'd13) begin bad++; $display("FAIL load13 got=%0d exp=13", hour); end
    do_load(5'd27);
    total++; if (hour !== 5'd13 || day_tick !== 1'b0) begin bad++; $display("FAIL load_illegal got=%0d dt=%0b exp=13/0", hour, day_tick); end
    mode_12h = 1'b1;
    #1;
    total++; if (disp_tens !== 4'd0 || disp_ones !== 4'd1 || pm !== 1'b1) begin bad++; $display("FAIL disp12_13 got=%0d/%0d pm=%0b exp=0/1/1", disp_tens, disp_ones, pm); end
    mode_12h = 1'b0;
    #1;
    total++; if (disp_tens !== 4'd1 || disp_ones !== 4'd3 || pm !== 1'b1) begin bad++; $display("FAIL disp24_13 got=%0d/%0d pm=%0b exp=1/3/1", disp_tens, disp_ones, pm); end
    mode_12h = 1'b1;
    do_load(5'd12);
    total++; if (disp_tens !== 4'd1 || disp_ones !== 4'd2 || pm !== 1'b1) begin bad++; $display("FAIL disp12_12 got=%0d/%0d pm=%0b exp=1/2/1", disp_tens, disp_ones, pm); end
    do_load(5'd23);
    total++; if (disp_tens !== 4'd1 || disp_ones !== 4'd1) begin bad++; $display("FAIL disp12_23 got=%0d/%0d exp=1/1", disp_tens, disp_ones); end
    do_load(5'd9);
    total++; if (disp_tens !== 4'd0 || disp_ones !== 4'd9 || pm !== 1'b0) begin bad++; $display("FAIL disp12_9 got=%0d/%0d pm=%0b exp=0/9/0", disp_tens, disp_ones, pm); end
    mode_12h = 1'b0;
    do_load(5'd23);
    total++; if (disp_tens !== 4'd2 || disp_ones !== 4'd3) begin bad++; $display("FAIL disp24_23 got=%0d/%0d exp=2/3", disp_tens, disp_ones); end
  endtask

  task automatic test_repeat;
    logic [4:0] exp_h [10];
    exp_h = '{5'd23, 5'd23, 5'd23, 5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1};
    do_load(5'd22);
    set_mode = 1'b1;
    btn_up   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (hour !== exp_h[i] || day_tick !== 1'b0) begin bad++; $display("FAIL repeat_c%0d got=%0d dt=%0b exp=%0d/0", i, hour, day_tick, exp_h[i]); end
    end
    btn_up = 1'b0;
    tick();
    total++; if (hour !== 5'd1) begin bad++; $display("FAIL repeat_release got=%0d exp=1", hour); end
    set_mode = 1'b0;
  endtask

  task automatic test_down_ignore;
    set_mode = 1'b1;
    do_load(5'd0);
    btn_down = 1'b1;
    tick();
    btn_down = 1'b0;
    total++; if (hour !== 5'd23 || day_tick !== 1'b0) begin bad++; $display("FAIL down_wrap got=%0d dt=%0b exp=23/0", hour, day_tick); end
    tick();
    minute_enable = 1'b1;
    tick();
    tick();
    minute_enable = 1'b0;
    total++; if (hour !== 5'd23 || day_tick !== 1'b0) begin bad++; $display("FAIL minute_ignored got=%0d dt=%0b exp=23/0", hour, day_tick); end
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick();
    tick();
    total++; if (hour !== 5'd23) begin bad++; $display("FAIL both_buttons got=%0d exp=23", hour); end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    set_mode = 1'b0;
    tick();
    total++; if (hour !== 5'd23 || day_tick !== 1'b0) begin bad++; $display("FAIL not_queued got=%0d dt=%0b exp=23/0", hour, day_tick); end
  endtask

  task automatic test_back_to_back;
    set_mode      = 1'b1;
    load_value    = 5'd5;
    load1         = 1'b1;
    minute_enable = 1'b1;
    btn_up        = 1'b1;
    tick();
    load1         = 1'b0;
    minute_enable = 1'b0;
    total++; if (hour !== 5'd5) begin bad++; $display("FAIL same_edge_load got=%0d exp=5", hour); end
    repeat (5) tick();
    total++; if (hour !== 5'd5) begin bad++; $display("FAIL held_after_load got=%0d exp=5", hour); end
    btn_up = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    total++; if (hour !== 5'd6) begin bad++; $display("FAIL repress_after_load got=%0d exp=6", hour); end
    btn_up   = 1'b0;
    set_mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_hold;
    set_mode = 1'b1;
    do_load(5'd8);
    btn_up = 1'b1;
    tick();
    total++; if (hour !== 5'd9) begin bad++; $display("FAIL hold_first_step got=%0d exp=9", hour); end
    tick();
    reset = 1'b0;
    #1;
    total++; if (hour !== 5'd0) begin bad++; $display("FAIL mid_hold_reset got=%0d exp=0", hour); end
    tick();
    reset = 1'b1;
    repeat (6) tick();
    total++; if (hour !== 5'd0) begin bad++; $display("FAIL held_after_reset got=%0d exp=0", hour); end
    btn_up = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    total++; if (hour !== 5'd1) begin bad++; $display("FAIL repress_after_reset got=%0d exp=1", hour); end
    btn_up   = 1'b0;
    set_mode = 1'b0;
    tick();
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    minute_enable = 1'b0;
    load1         = 1'b0;
    load_value    = 5'd0;
    set_mode      = 1'b0;
    btn_up        = 1'b0;
    btn_down      = 1'b0;
    mode_12h      = 1'b0;
    test_reset();
    test_minute();
    test_load_display();
    test_repeat();
    test_down_ignore();
    test_back_to_back();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hour_counter.md
HOUR_COUNTER -- requirements
Module: hour_counter

Interface
REQ-001 Parameter REPEAT_DIV, default 50000000: clk cycles between auto-repeat steps while a set button is held.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-004 minute_enable  input  1  one-cycle advance pulse from the minute/hour divider; advances hour by one.
REQ-005 load1  input  1  one-cycle load strobe.
REQ-006 load_value  input  5  binary hour to load, legal range 0-23.
REQ-007 set_mode  input  1  high = manual set mode; buttons active, minute_enable ignored.
REQ-008 btn_up  input  1  synchronized, debounced level; increment request.
REQ-009 btn_down  input  1  synchronized, debounced level; decrement request.
REQ-010 mode_12h  input  1  display format select: 1 = 12-hour, 0 = 24-hour.
REQ-011 hour  output  5  registered binary hour, 0-23.
REQ-012 disp_tens  output  4  BCD tens digit of displayed hour.
REQ-013 disp_ones  output  4  BCD ones digit of displayed hour.
REQ-014 pm  output  1  high when hour >= 12, both display modes.
REQ-015 thresh  output  1  level, high when hour == 23; drives the next-stage divider thresh input.
REQ-016 day_tick  output  1  registered one-cycle pulse on 23->0 wrap caused by minute_enable.

Function
REQ-017 Priority per cycle SHALL be: load1 > set-mode button action > minute_enable.
REQ-018 load1 with load_value 0-23 SHALL set hour = load_value on that edge; load_value 24-31 SHALL leave hour unchanged; load never asserts day_tick.
REQ-019 minute_enable with set_mode low and no load SHALL increment hour; at 23, hour wraps to 0 and day_tick is high for the next cycle only.
REQ-020 minute_enable while set_mode is high SHALL be ignored (dropped, not queued).
REQ-021 Button FSM states SHALL be IDLE, HELD_UP, HELD_DOWN; it is active only while set_mode is high.
REQ-022 IDLE -> HELD_UP on btn_up high and btn_down low; hour +1 on that same edge, repeat counter cleared.
REQ-023 IDLE -> HELD_DOWN on btn_down high and btn_up low; hour -1 on that same edge, repeat counter cleared.
REQ-024 In HELD_x, the repeat counter increments each cycle; when it reaches REPEAT_DIV-1, hour steps again in the same direction and the counter clears.
REQ-025 HELD_x -> IDLE when its button is released, the other button is pressed, or set_mode drops; no step occurs on that edge.
REQ-026 Both buttons high in IDLE: no step, remain IDLE.
REQ-027 Button steps SHALL wrap 23->0 (up) and 0->23 (down) and never assert day_tick.
REQ-028 load1 during HELD_x SHALL load and return the FSM to IDLE; the held button does not re-trigger until it is released and pressed again.
REQ-029 24-hour mode: disp_tens/disp_ones = BCD of hour.
REQ-030 12-hour mode: hour 0 -> 12, hours 1-12 -> unchanged, hours 13-23 -> hour-12, shown as BCD.
REQ-031 disp_*, pm and thresh SHALL be combinational decodes of the hour register (zero added latency); mode_12h changes take effect in the same cycle.
REQ-032 The repeat counter SHALL be wide enough for REPEAT_DIV-1 with no overflow.

Reset
REQ-033 reset low SHALL force hour=0, day_tick=0, FSM=IDLE, repeat counter=0; outputs then read disp 0/0 (24h) or 1/2 (12h), pm=0, thresh=0.
REQ-034 reset asserted mid-hold SHALL abort the hold; after release, a still-held button does not step until it is released and pressed again.

Verification
REQ-035 load1 with load_value=23, then one minute_enable pulse -> hour=0, day_tick high exactly one cycle, thresh 1->0.
REQ-036 load_value=27 with load1 -> hour unchanged; load_value=13, mode_12h=1 -> disp 0/1, pm=1; mode_12h=0 -> disp 1/3.
REQ-037 REPEAT_DIV=4, set_mode=1, hour=22, btn_up held 10 cycles -> steps at cycles 0, 4 and 8 -> hour 23, 0, 1; day_tick never asserted.
REQ-038 set_mode=1, hour=0, btn_down pulse -> hour=23; minute_enable pulses during set_mode -> ignored.
REQ-039 Same edge: load1 (value 5), minute_enable and btn_up press -> hour=5, FSM=IDLE.
REQ-040 reset pulsed low mid-hold with hour=9 -> immediate hour=0; btn_up still held after release -> no step until it is released and re-pressed.
